// File: rtl/spi_avalon_ctrl.sv
// Avalon-MM front end for the mode-0 SPI core: TX/RX word FIFOs around a
// launch / wait / capture sequencer that counts the core's per-byte ss_n releases.
`timescale 1ns/1ps
module spi_avalon_ctrl #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYC    = 1024,
  parameter int BYTES_PER_WORD = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  output logic        spi_go,
  output logic [31:0] spi_wdata,
  input  logic [31:0] spi_rdata,
  input  logic        spi_ss_n
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = $clog2(BYTES_PER_WORD + 1);
  localparam int WW = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_CAPTURE} state_e;
  state_e state_q, state_d;

  logic [31:0]   tx_mem_q [FIFO_DEPTH];
  logic [31:0]   rx_mem_q [FIFO_DEPTH];
  logic [PW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [PW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [EW-1:0] edge_cnt_q, edge_cnt_d;
  logic [WW-1:0] wd_q, wd_d;
  logic          enable_q, enable_d, irq_en_q, irq_en_d;
  logic          rx_ovf_q, rx_ovf_d, timeout_q, timeout_d, tx_ovf_q, tx_ovf_d;
  logic          ss_n_q, irq_q, irq_d, spi_go_q, spi_go_d;
  logic [31:0]   readdata_q, readdata_d, spi_wdata_q, spi_wdata_d;
  logic [31:0]   status_w, rd_mux;
  logic [15:0]   tx_cnt16, rx_cnt16;

  logic host_rd, host_wr, sts_wr;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push, tx_pop, rx_push, rx_pop;
  logic ss_rise, words_done, wd_expired;

  // Avalon slave: a strobe is accepted on every clk edge (no waitrequest);
  // read data appears in readdata one cycle after the read&chipselect edge.
  assign host_rd = chipselect & read;
  assign host_wr = chipselect & write;
  assign sts_wr  = host_wr & (address == 2'd2);

  assign tx_full  = (tx_cnt_q == CW'(FIFO_DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == CW'(FIFO_DEPTH));
  assign rx_empty = (rx_cnt_q == '0);

  assign tx_push = host_wr & (address == 2'd0) & ~tx_full;
  assign tx_pop  = (state_q == S_LAUNCH);
  assign rx_pop  = host_rd & (address == 2'd1) & ~rx_empty;
  // A host pop in the capture cycle frees the slot the new word needs.
  assign rx_push = (state_q == S_CAPTURE) & (~rx_full | rx_pop);

  assign ss_rise    = spi_ss_n & ~ss_n_q;
  assign words_done = (edge_cnt_q == EW'(BYTES_PER_WORD));
  assign wd_expired = (wd_q == WW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (enable_q && !tx_empty) state_d = S_LAUNCH;
      S_LAUNCH:  state_d = S_WAIT;
      S_WAIT: begin
        if (words_done)      state_d = S_CAPTURE;
        else if (wd_expired) state_d = S_IDLE;
      end
      S_CAPTURE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_wr_d    = tx_wr_q;
    tx_rd_d    = tx_rd_q;
    rx_wr_d    = rx_wr_q;
    rx_rd_d    = rx_rd_q;
    edge_cnt_d = edge_cnt_q;
    wd_d       = wd_q;
    enable_d   = enable_q;
    irq_en_d   = irq_en_q;
    if (tx_push) tx_wr_d = tx_wr_q + 1'b1;
    if (tx_pop)  tx_rd_d = tx_rd_q + 1'b1;
    if (rx_push) rx_wr_d = rx_wr_q + 1'b1;
    if (rx_pop)  rx_rd_d = rx_rd_q + 1'b1;
    tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);

    if (state_q == S_LAUNCH) begin
      edge_cnt_d = '0;
      wd_d       = '0;
    end else if (state_q == S_WAIT) begin
      wd_d = wd_q + 1'b1;
      if (ss_rise && !words_done) edge_cnt_d = edge_cnt_q + 1'b1;
    end

    // Sticky flags: a set in the same cycle as its W1C wins.
    tx_ovf_d  = (tx_ovf_q & ~(sts_wr & writedata[7])) |
                (host_wr & (address == 2'd0) & tx_full);
    rx_ovf_d  = (rx_ovf_q & ~(sts_wr & writedata[5])) |
                ((state_q == S_CAPTURE) & rx_full & ~rx_pop);
    timeout_d = (timeout_q & ~(sts_wr & writedata[6])) |
                ((state_q == S_WAIT) & ~words_done & wd_expired);

    if (host_wr && address == 2'd3) begin
      enable_d = writedata[0];
      irq_en_d = writedata[1];
    end

    irq_d       = irq_en_q & (~rx_empty | rx_ovf_q | timeout_q);
    spi_go_d    = tx_pop;
    spi_wdata_d = tx_pop ? tx_mem_q[tx_rd_q] : spi_wdata_q;

    tx_cnt16        = 16'(tx_cnt_q);
    rx_cnt16        = 16'(rx_cnt_q);
    status_w        = '0;
    status_w[0]     = (state_q != S_IDLE);
    status_w[1]     = tx_full;
    status_w[2]     = tx_empty;
    status_w[3]     = rx_full;
    status_w[4]     = rx_empty;
    status_w[5]     = rx_ovf_q;
    status_w[6]     = timeout_q;
    status_w[7]     = tx_ovf_q;
    status_w[11:8]  = tx_cnt16[3:0];
    status_w[15:12] = rx_cnt16[3:0];

    rd_mux = '0;
    unique case (address)
      2'd1:    rd_mux = rx_empty ? 32'h0 : rx_mem_q[rx_rd_q];
      2'd2:    rd_mux = status_w;
      2'd3:    rd_mux = {30'h0, irq_en_q, enable_q};
      default: rd_mux = '0;
    endcase
    readdata_d = host_rd ? rd_mux : readdata_q;
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wr_q] <= writedata;
    if (rx_push) rx_mem_q[rx_wr_q] <= spi_rdata;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      tx_wr_q     <= '0;
      tx_rd_q     <= '0;
      rx_wr_q     <= '0;
      rx_rd_q     <= '0;
      tx_cnt_q    <= '0;
      rx_cnt_q    <= '0;
      edge_cnt_q  <= '0;
      wd_q        <= '0;
      enable_q    <= 1'b0;
      irq_en_q    <= 1'b0;
      rx_ovf_q    <= 1'b0;
      timeout_q   <= 1'b0;
      tx_ovf_q    <= 1'b0;
      ss_n_q      <= 1'b1;
      irq_q       <= 1'b0;
      spi_go_q    <= 1'b0;
      readdata_q  <= '0;
      spi_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      tx_wr_q     <= tx_wr_d;
      tx_rd_q     <= tx_rd_d;
      rx_wr_q     <= rx_wr_d;
      rx_rd_q     <= rx_rd_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      edge_cnt_q  <= edge_cnt_d;
      wd_q        <= wd_d;
      enable_q    <= enable_d;
      irq_en_q    <= irq_en_d;
      rx_ovf_q    <= rx_ovf_d;
      timeout_q   <= timeout_d;
      tx_ovf_q    <= tx_ovf_d;
      ss_n_q      <= spi_ss_n;
      irq_q       <= irq_d;
      spi_go_q    <= spi_go_d;
      readdata_q  <= readdata_d;
      spi_wdata_q <= spi_wdata_d;
    end
  end

  assign readdata  = readdata_q;
  assign irq       = irq_q;
  assign spi_go    = spi_go_q;
  assign spi_wdata = spi_wdata_q;

endmodule

// File: tb/tb_spi_avalon_ctrl.sv
// Bench for spi_avalon_ctrl: Avalon host driver, behavioural SPI core model,
// queue-based reference model and decoupled read/launch monitors.
`timescale 1ns/1ps
module tb_spi_avalon_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect, read, write;
  logic [31:0] writedata, readdata;
  logic        irq, spi_go;
  logic [31:0] spi_wdata, spi_rdata;
  logic        spi_ss_n;

  always #5 clk = ~clk;

  spi_avalon_ctrl #(.FIFO_DEPTH(4), .TIMEOUT_CYC(64), .BYTES_PER_WORD(4)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read(read), .write(write), .writedata(writedata), .readdata(readdata),
    .irq(irq), .spi_go(spi_go), .spi_wdata(spi_wdata), .spi_rdata(spi_rdata),
    .spi_ss_n(spi_ss_n)
  );

  int chk = 0;
  int errs = 0;
  logic [31:0] exp_q[$];
  string       exp_nm_q[$];
  logic [31:0] exp_launch_q[$];
  logic [31:0] core_resp_q[$];
  logic [31:0] ref_tx[$], ref_resp[$], ref_rx[$];
  logic        m_rx_ovf = 1'b0, m_to = 1'b0, m_tx_ovf = 1'b0;
  int          pulses_cfg = 4;
  int          rise_cnt = 0;
  int          launches = 0;
  logic        core_active = 1'b0;
  logic        rd_v = 1'b0;
  logic [31:0] core_r;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s        = '0;
    s[1]     = (ref_tx.size() == 4);
    s[2]     = (ref_tx.size() == 0);
    s[3]     = (ref_rx.size() == 4);
    s[4]     = (ref_rx.size() == 0);
    s[5]     = m_rx_ovf;
    s[6]     = m_to;
    s[7]     = m_tx_ovf;
    s[11:8]  = 4'(ref_tx.size());
    s[15:12] = 4'(ref_rx.size());
    return s;
  endfunction

  // Every queued word is sent; a full word delivers its response to RX.
  task automatic ref_run_tx();
    logic [31:0] w, r;
    while (ref_tx.size() > 0) begin
      w = ref_tx.pop_front();
      r = ref_resp.pop_front();
      if (pulses_cfg >= 4) begin
        if (ref_rx.size() < 4) ref_rx.push_back(r);
        else m_rx_ovf = 1'b1;
      end else begin
        m_to = 1'b1;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write = 1'b1;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic host_read(input logic [1:0] a, input logic [31:0] exp, input string nm);
    exp_q.push_back(exp);
    exp_nm_q.push_back(nm);
    address = a; chipselect = 1'b1; read = 1'b1;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic host_tx(input logic [31:0] w, input logic [31:0] r);
    if (ref_tx.size() < 4) begin
      ref_tx.push_back(w);
      ref_resp.push_back(r);
      exp_launch_q.push_back(w);
      core_resp_q.push_back(r);
    end else begin
      m_tx_ovf = 1'b1;
    end
    bus_write(2'd0, w);
  endtask

  task automatic host_w1c(input logic [31:0] m);
    if (m[5]) m_rx_ovf = 1'b0;
    if (m[6]) m_to = 1'b0;
    if (m[7]) m_tx_ovf = 1'b0;
    bus_write(2'd2, m);
  endtask

  task automatic read_rx(input string nm);
    logic [31:0] e;
    e = (ref_rx.size() > 0) ? ref_rx.pop_front() : 32'h0;
    host_read(2'd1, e, nm);
  endtask

  task automatic read_status(input string nm);
    host_read(2'd2, exp_status(), nm);
  endtask

  task automatic wait_idle(input int need);
    int quiet, cyc;
    quiet = 0; cyc = 0;
    while (quiet < need && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (core_active || spi_go) quiet = 0;
      else quiet++;
    end
    chk++;
    if (quiet < need) begin
      errs++;
      $display("FAIL wait_idle actual_quiet=%0d required=%0d", quiet, need);
    end
  endtask

  task automatic wait_go(input string nm);
    int j;
    j = 0;
    while (spi_go !== 1'b1 && j < 40) begin
      @(negedge clk);
      j++;
    end
    check(nm, spi_go, 1'b1);
  endtask

  // ---------------- SPI core model ----------------
  initial begin
    spi_ss_n = 1'b1;
    spi_rdata = '0;
    forever begin
      @(negedge clk);
      if (spi_go === 1'b1) begin
        core_active = 1'b1;
        core_r = (core_resp_q.size() > 0) ? core_resp_q.pop_front() : 32'h0;
        for (int p = 0; p < pulses_cfg; p++) begin
          spi_ss_n = 1'b0;
          repeat ($urandom_range(2, 5)) @(negedge clk);
          spi_ss_n = 1'b1;
          if (p == pulses_cfg - 1) begin
            spi_rdata = core_r;
            rise_cnt++;
          end
          repeat (2) @(negedge clk);
        end
        core_active = 1'b0;
      end
    end
  end

  // ---------------- monitors ----------------
  always @(posedge clk) rd_v <= reset_n & chipselect & read;

  initial forever begin
    @(negedge clk);
    if (rd_v) begin
      if (exp_q.size() == 0) begin
        chk++; errs++;
        $display("FAIL unexpected_read actual=%h required=none", readdata);
      end else begin
        check(exp_nm_q.pop_front(), readdata, exp_q.pop_front());
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (spi_go === 1'b1) begin
      launches++;
      if (exp_launch_q.size() == 0) begin
        chk++; errs++;
        $display("FAIL unexpected_spi_go actual_wdata=%h required=no_launch", spi_wdata);
      end else begin
        check("spi_wdata", spi_wdata, exp_launch_q.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    errs++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", chk, errs);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    int lb, start, cnt, n, m;
    logic [31:0] w5, r5, tmp;
    address = '0; writedata = '0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", irq, 1'b0);
    check("rst_spi_go", spi_go, 1'b0);
    check("rst_spi_wdata", spi_wdata, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    read_status("rst_status");
    host_read(2'd3, 32'h0, "rst_control");

    // single word with launch latency
    bus_write(2'd3, 32'h1);
    host_tx(32'hA5C3_0F81, 32'h1234_5678);
    check("lat_k", spi_go, 1'b0);
    @(negedge clk); check("lat_k1", spi_go, 1'b0);
    @(negedge clk); check("lat_k2", spi_go, 1'b1);
    check("lat_wdata", spi_wdata, 32'hA5C3_0F81);
    @(negedge clk); check("lat_k3", spi_go, 1'b0);
    ref_run_tx();
    wait_idle(12);
    read_rx("single_rx");
    read_status("single_status");

    // TX overflow with the sequencer disabled
    bus_write(2'd3, 32'h0);
    for (int i = 0; i < 5; i++) host_tx($urandom, $urandom);
    read_status("txovf_status");
    host_w1c(32'h80);
    lb = launches;
    bus_write(2'd3, 32'h1);
    ref_run_tx();
    wait_idle(12);
    check("txovf_launches", 32'(launches - lb), 32'd4);

    // RX overflow: fifth completed word with no reads
    host_tx($urandom, $urandom);
    ref_run_tx();
    wait_idle(12);
    read_status("rxovf_status");
    for (int i = 0; i < 4; i++) read_rx("rxovf_data");
    host_w1c(32'h20);
    read_status("rxovf_cleared");

    // host pop coinciding with capture into a full RX
    for (int i = 0; i < 4; i++) host_tx($urandom, $urandom);
    ref_run_tx();
    wait_idle(12);
    w5 = $urandom; r5 = $urandom;
    start = rise_cnt;
    host_tx(w5, r5);
    tmp = ref_tx.pop_front();
    tmp = ref_resp.pop_front();
    cnt = 0;
    while (rise_cnt == start && cnt < 300) begin
      @(posedge clk);
      cnt++;
    end
    check("sim_rise_seen", 32'(rise_cnt - start), 32'd1);
    repeat (2) @(negedge clk);
    read_rx("sim_pop_head");
    ref_rx.push_back(r5);
    wait_idle(12);
    read_status("sim_status");
    for (int i = 0; i < 4; i++) read_rx("sim_order");

    // randomized rounds
    for (int rnd = 0; rnd < 8; rnd++) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) host_tx($urandom, $urandom);
      ref_run_tx();
      wait_idle(12);
      m = $urandom_range(0, 5);
      for (int i = 0; i < m; i++) read_rx("rnd_rx");
      if ($urandom_range(0, 1) == 1) host_w1c($urandom_range(0, 255));
      read_status("rnd_status");
    end

    // watchdog timeout with irq enabled
    while (ref_rx.size() > 0) read_rx("to_drain");
    host_w1c(32'hE0);
    bus_write(2'd3, 32'h3);
    @(negedge clk);
    check("to_irq_pre", irq, 1'b0);
    pulses_cfg = 3;
    host_tx($urandom, $urandom);
    wait_go("to_go");
    cnt = 0;
    while (irq !== 1'b1 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check("to_irq_latency", 32'(cnt), 32'd65);
    ref_run_tx();
    wait_idle(12);
    pulses_cfg = 4;
    read_status("to_status");
    read_rx("to_rx_empty");
    host_w1c(32'h40);
    @(negedge clk);
    check("to_irq_cleared", irq, 1'b0);
    bus_write(2'd3, 32'h1);

    // reset during WAIT
    host_tx($urandom, $urandom);
    wait_go("rst2_go");
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    ref_tx.delete(); ref_resp.delete(); ref_rx.delete();
    m_rx_ovf = 1'b0; m_to = 1'b0; m_tx_ovf = 1'b0;
    check("rst2_readdata", readdata, 32'h0);
    check("rst2_irq", irq, 1'b0);
    check("rst2_spi_go", spi_go, 1'b0);
    check("rst2_spi_wdata", spi_wdata, 32'h0);
    read_status("rst2_status");
    lb = launches;
    bus_write(2'd3, 32'h1);
    wait_idle(20);
    check("rst2_no_go", 32'(launches - lb), 32'd0);
    host_tx(32'h0BAD_F00D, 32'hC001_D00D);
    ref_run_tx();
    wait_idle(12);
    read_rx("rst2_new_rx");

    repeat (4) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("launch_q_drained", 32'(exp_launch_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", chk, errs);
    $finish;
  end

endmodule
